// File: rtl/clock_mon_pkg.sv
// Shared types and constants for the clock edge monitor.
package clock_mon_pkg;

  // Measurement FSM states; encodings are fixed and shared with other blocks.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    TRACK = 2'd2,
    STALL = 2'd3
  } state_t;

  // Consecutive matching periods (after the reference) needed to declare lock.
  localparam int unsigned MATCH_W      = 2;
  localparam logic [MATCH_W-1:0] LOCK_MATCHES = 2'd2;

endpackage : clock_mon_pkg

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop with rise/fall edge detection.
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic       sync3;
  logic [2:0] primed;

  // Synchronizer chain; primed tracks which stages hold post-reset samples so
  // a level already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      primed <= 3'b000;
    end else begin
      sync1  <= async_in;
      sync2  <= sync1;
      sync3  <= sync2;
      primed <= {primed[1:0], 1'b1};
    end
  end

  assign rise = primed[2] &  sync2 & ~sync3;
  assign fall = primed[2] & ~sync2 &  sync3;

endmodule : sync_edge

// File: rtl/clock_edge_monitor.sv
// Measures the rising-to-rising period of a slow asynchronous signal, flags
// lock after repeated matching periods and a sticky timeout on edge loss.
module clock_edge_monitor
  import clock_mon_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 20,
  parameter int unsigned TOLERANCE = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 slow_clock,
  input  logic                 clear,
  output logic                 tick,
  output logic                 tick_fall,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam int unsigned DW = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 rise;
  logic                 fall;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [CNT_WIDTH-1:0] period_d;
  logic                 period_valid_d;
  logic                 locked_d;
  logic                 timeout_d;
  logic [DW-1:0]        diff_c;
  logic                 within_tol_c;
  logic [MATCH_W-1:0]   match_inc_c;

  sync_edge u_sync_edge (
    .clock    (clock),
    .reset    (reset),
    .async_in (slow_clock),
    .rise     (rise),
    .fall     (fall)
  );

  // Unsigned magnitude of new vs previous period, one bit wider so it never wraps.
  always_comb begin
    if (counter_q >= period) diff_c = {1'b0, counter_q} - {1'b0, period};
    else                     diff_c = {1'b0, period} - {1'b0, counter_q};
    within_tol_c = (diff_c <= DW'(TOLERANCE));
    match_inc_c  = (match_q == LOCK_MATCHES) ? LOCK_MATCHES : match_q + MATCH_W'(1);
  end

  // State and measurement registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      match_q      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      tick         <= 1'b0;
      tick_fall    <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      match_q      <= match_d;
      period       <= period_d;
      period_valid <= period_valid_d;
      locked       <= locked_d;
      timeout      <= timeout_d;
      tick         <= rise;
      tick_fall    <= fall;
    end
  end

  // Next-state and measurement update; clear overrides any coincident edge.
  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    match_d        = match_q;
    period_d       = period;
    period_valid_d = 1'b0;
    locked_d       = locked;
    timeout_d      = timeout;

    if (clear) begin
      state_d   = IDLE;
      counter_d = '0;
      match_d   = '0;
      period_d  = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          counter_d = '0;
          if (rise) begin
            state_d   = FIRST;
            counter_d = CNT_WIDTH'(1);
          end
        end
        FIRST, TRACK: begin
          if (rise) begin
            state_d        = TRACK;
            period_d       = counter_q;
            period_valid_d = 1'b1;
            counter_d      = CNT_WIDTH'(1);
            if (state_q == FIRST) begin
              match_d = '0;
            end else if (within_tol_c) begin
              match_d  = match_inc_c;
              locked_d = (match_inc_c == LOCK_MATCHES);
            end else begin
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (counter_q == CNT_MAX) begin
            state_d   = STALL;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
          end else begin
            counter_d = counter_q + CNT_WIDTH'(1);
          end
        end
        STALL: begin
          if (rise) begin
            state_d   = FIRST;
            counter_d = CNT_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule : clock_edge_monitor

// File: tb/tb_clock_edge_monitor.sv
// Directed, table-driven bench for clock_edge_monitor (CNT_WIDTH = 6).
module tb_clock_edge_monitor;
  import clock_mon_pkg::*;

  localparam int unsigned CW = 6;

  logic          clock;
  logic          reset;
  logic          slow_clock;
  logic          clear;
  logic          tick;
  logic          tick_fall;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          timeout;

  typedef struct {
    int unsigned per;
    logic        exp_locked;
    int unsigned exp_match;
  } vec_t;

  typedef struct {
    int unsigned per;
    logic        lk;
    int unsigned mc;
    logic        tk;
  } upd_t;

  vec_t vecs[14];
  upd_t upd_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   tick_cnt = 0;

  clock_edge_monitor #(.CNT_WIDTH(CW), .TOLERANCE(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .slow_clock   (slow_clock),
    .clear        (clear),
    .tick         (tick),
    .tick_fall    (tick_fall),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every period update and count ticks, sampled away from the active edge.
  always @(negedge clock) begin
    if (period_valid)
      upd_q.push_back('{32'(period), locked, 32'(dut.match_q), tick});
    if (tick) tick_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One slow_clock period of n clock cycles, beginning with a rising edge.
  task automatic gen_period(input int unsigned n);
    slow_clock = 1'b1;
    repeat (n / 2) @(negedge clock);
    slow_clock = 1'b0;
    repeat (n - n / 2) @(negedge clock);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  // Drive vecs[lo..hi] as consecutive periods, close with one more rise, compare updates.
  task automatic run_seq(input int lo, input int hi, input bit do_clear);
    if (do_clear) pulse_clear();
    upd_q.delete();
    for (int i = lo; i <= hi; i++) gen_period(vecs[i].per);
    slow_clock = 1'b1;
    repeat (8) @(negedge clock);
    slow_clock = 1'b0;
    repeat (4) @(negedge clock);
    check($sformatf("seq%0d_update_count", lo), upd_q.size(), hi - lo + 1);
    for (int i = lo; i <= hi; i++) begin
      if (i - lo < upd_q.size()) begin
        check($sformatf("vec%0d_period", i), upd_q[i-lo].per, vecs[i].per);
        check($sformatf("vec%0d_locked", i), 32'(upd_q[i-lo].lk), 32'(vecs[i].exp_locked));
        check($sformatf("vec%0d_match", i), upd_q[i-lo].mc, vecs[i].exp_match);
        check($sformatf("vec%0d_tick_with_valid", i), 32'(upd_q[i-lo].tk), 1);
      end
    end
  endtask

  initial begin
    bit got;
    int snap;

    // 16-cycle periods: lock after the third update.
    vecs[0]  = '{16, 1'b0, 0};
    vecs[1]  = '{16, 1'b0, 1};
    vecs[2]  = '{16, 1'b1, 2};
    vecs[3]  = '{16, 1'b1, 2};
    vecs[4]  = '{16, 1'b1, 2};
    // Jitter within tolerance locks, 25 and 22 (diff 3) break it.
    vecs[5]  = '{20, 1'b0, 0};
    vecs[6]  = '{21, 1'b0, 1};
    vecs[7]  = '{19, 1'b1, 2};
    vecs[8]  = '{25, 1'b0, 0};
    vecs[9]  = '{22, 1'b0, 0};
    // Edge coinciding with counter saturation is still a valid period.
    vecs[10] = '{63, 1'b0, 0};
    // Re-lock after clear.
    vecs[11] = '{16, 1'b0, 0};
    vecs[12] = '{16, 1'b0, 1};
    vecs[13] = '{16, 1'b1, 2};

    reset = 1'b0;
    slow_clock = 1'b0;
    clear = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {26'd0, tick, tick_fall, period_valid, locked, timeout, |period}, 0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b1;
    repeat (4) @(negedge clock);

    run_seq(0, 4, 1'b1);
    run_seq(5, 9, 1'b1);
    run_seq(10, 10, 1'b1);
    check("sat_edge_no_timeout", 32'(timeout), 0);

    // Single edge then silence: timeout exactly when counter saturates in FIRST.
    pulse_clear();
    slow_clock = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clock);
      if (tick) got = 1'b1;
    end
    check("to_first_tick", 32'(got), 1);
    slow_clock = 1'b0;
    check("to_enter_first", 32'(dut.state_q), 32'(FIRST));
    repeat (62) @(negedge clock);
    check("to_before_sat", 32'(timeout), 0);
    check("to_before_sat_state", 32'(dut.state_q), 32'(FIRST));
    @(negedge clock);
    check("to_flag", 32'(timeout), 1);
    check("to_state_stall", 32'(dut.state_q), 32'(STALL));
    repeat (3) @(negedge clock);
    check("to_counter_held", 32'(dut.counter_q), 63);
    slow_clock = 1'b1;
    repeat (3) @(negedge clock);
    check("to_rise_to_first", 32'(dut.state_q), 32'(FIRST));
    check("to_sticky", 32'(timeout), 1);
    slow_clock = 1'b0;
    repeat (4) @(negedge clock);
    pulse_clear();
    check("clear_drops_timeout", 32'(timeout), 0);

    // Lock, then clear coinciding with a rise: edge discarded, tick still seen.
    repeat (4) @(negedge clock);
    for (int i = 0; i < 4; i++) gen_period(16);
    check("pre_clear_locked", 32'(locked), 1);
    slow_clock = 1'b1;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_tick", 32'(tick), 1);
    check("clr_no_valid", 32'(period_valid), 0);
    check("clr_locked", 32'(locked), 0);
    check("clr_period", 32'(period), 0);
    check("clr_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clock);
    check("clr_edge_discarded", 32'(dut.state_q), 32'(IDLE));
    slow_clock = 1'b0;
    repeat (4) @(negedge clock);
    run_seq(11, 13, 1'b0);

    // Asynchronous reset while locked, released with slow_clock already high.
    check("pre_reset_locked", 32'(locked), 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", {26'd0, tick, tick_fall, period_valid, locked, timeout, |period}, 0);
    check("async_reset_state", 32'(dut.state_q), 32'(IDLE));
    slow_clock = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    snap = tick_cnt;
    repeat (6) @(negedge clock);
    check("release_high_no_tick", tick_cnt - snap, 0);
    check("release_high_idle", 32'(dut.state_q), 32'(IDLE));
    slow_clock = 1'b0;
    repeat (4) @(negedge clock);
    upd_q.delete();
    slow_clock = 1'b1;
    @(negedge clock);
    check("post_rst_tick_c1", 32'(tick), 0);
    @(negedge clock);
    check("post_rst_tick_c2", 32'(tick), 0);
    @(negedge clock);
    check("post_rst_tick_c3", 32'(tick), 1);
    check("post_rst_no_valid", 32'(period_valid), 0);
    @(negedge clock);
    check("post_rst_tick_one_cycle", 32'(tick), 0);
    check("post_rst_state_first", 32'(dut.state_q), 32'(FIRST));
    slow_clock = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("tick_fall_c2", 32'(tick_fall), 0);
    @(negedge clock);
    check("tick_fall_c3", 32'(tick_fall), 1);
    @(negedge clock);
    check("tick_fall_one_cycle", 32'(tick_fall), 0);
    check("post_rst_no_updates", upd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_clock_edge_monitor

// File: doc/clock_edge_monitor.md
CLOCK_EDGE_MONITOR -- requirements
Module: clock_edge_monitor

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 20: width of the period counter and the period output.
REQ-002 SHALL have parameter TOLERANCE, default 2: maximum period difference, in clock cycles, counted as a match.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port slow_clock, input, 1 bit: the divided clock or slow signal under monitor, asynchronous to clock.
REQ-006 SHALL have port clear, input, 1 bit: synchronous restart of measurement, active-high.
REQ-007 SHALL have port tick, output, 1 bit: one-cycle pulse per synchronized rising edge of slow_clock.
REQ-008 SHALL have port tick_fall, output, 1 bit: one-cycle pulse per synchronized falling edge of slow_clock.
REQ-009 SHALL have port period, output, CNT_WIDTH bits: last measured rising-to-rising interval, in clock cycles.
REQ-010 SHALL have port period_valid, output, 1 bit: one-cycle pulse when period updates.
REQ-011 SHALL have port locked, output, 1 bit: high while the measured period is stable.
REQ-012 SHALL have port timeout, output, 1 bit: sticky flag, set when no rising edge arrives before counter saturation.

Function
REQ-013 SHALL pass slow_clock through a two-flop synchronizer (sync1, sync2) plus a history flop (sync3); rise = sync2 & ~sync3, fall = ~sync2 & sync3.
REQ-014 SHALL register tick and tick_fall from rise and fall: slow_clock sampled high at clock edge k -> tick high for exactly the cycle after edge k+2.
REQ-015 SHALL implement FSM states IDLE, FIRST, TRACK, STALL.
REQ-016 IDLE: counter held at 0; on rise -> FIRST with counter = 1.
REQ-017 FIRST: counter increments each cycle; on rise: period = counter, period_valid pulses, counter = 1, -> TRACK; match_cnt = 0.
REQ-018 TRACK: on rise: period = counter, period_valid pulses, counter = 1; if |counter - period_old| <= TOLERANCE then match_cnt increments (saturating at 2), else match_cnt = 0 and locked = 0.
REQ-019 locked SHALL assert on the cycle match_cnt reaches 2 (three consecutive matching periods) and stay high until a mismatch, timeout, clear or reset.
REQ-020 Difference SHALL be computed unsigned-magnitude at CNT_WIDTH+1 bits; no wrap-around.
REQ-021 In FIRST or TRACK, counter reaching all-ones with no rise: timeout = 1, locked = 0, match_cnt = 0, -> STALL.
REQ-022 STALL: counter held; on rise -> FIRST with counter = 1; timeout stays set.
REQ-023 For a slow_clock of constant period N clock cycles, period SHALL equal N exactly.
REQ-024 period_valid and tick SHALL assert in the same cycle for the same edge.
REQ-025 clear SHALL force IDLE, counter = 0, match_cnt = 0, locked = 0, timeout = 0, period = 0 next cycle; clear beats a simultaneous rise (edge discarded, tick still emitted).
REQ-026 A rise coinciding with counter saturation SHALL count as a valid edge (no timeout).

Reset
REQ-027 reset low SHALL immediately clear sync1..sync3, counter, match_cnt, period, and all outputs to 0, and FSM to IDLE, regardless of clock.
REQ-028 Release of reset mid-cycle of slow_clock SHALL not produce a tick unless slow_clock is sampled low then high after release.

Structure
REQ-029 State encodings (IDLE=0, FIRST=1, TRACK=2, STALL=3) SHALL live in a shared package/header clock_mon_pkg.
REQ-030 Synchronizer and edge detection SHALL be one sub-module, sync_edge (ports clock, reset, async_in, rise, fall).

Verification
REQ-031 slow_clock from the team clock divider chain, period 16 clock cycles, 5 periods -> period = 16 on each period_valid; locked high after the third update.
REQ-032 Periods 20, 21, 19, 25 -> match_cnt 1, 2 (locked = 1), then mismatch at 25: locked = 0.
REQ-033 CNT_WIDTH = 6, slow_clock held low after one edge -> timeout = 1 after 63 cycles in FIRST, state STALL; next rise -> FIRST, timeout remains 1.
REQ-034 clear pulsed while locked -> next cycle locked = 0, period = 0, state IDLE; 3 further edges re-lock.
REQ-035 reset asserted mid-period while locked -> all outputs 0 asynchronously; after release, first rise at slow_clock produces tick 3 cycles later and no period_valid.
